zap_mem_drain_walker: RTL

- Read-side companion to the single-cycle-invalidate RAM block.
- On a start pulse it sweeps every row of the RAM's read port: addresses 0..DEPTH-1, in order.
- It discards rows whose valid bit is clear and streams the valid rows (address + data) out on a valid/ready interface, e.g. to a writeback or snapshot path.
- When built with the optional feature, it ends the sweep with a bulk invalidate pulse to the RAM.

---
 rtl/zap_mem_drain_walker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/zap_mem_drain_walker.sv
// zap_mem_drain_walker: sweeps every row of a RAM read port (0..DEPTH-1),
// drops rows with the valid bit clear and streams valid rows {addr, data}
// out through a small first-word-fall-through buffer on a valid/ready port.
// Read issue is credit-limited so the buffer can never overflow, even though
// the RAM pipeline itself is never stalled.
// Optional build macro ZAP_MEM_DRAIN_INV_EN: the FLUSH cycle at the end of
// the sweep pulses o_inv to bulk-invalidate the RAM.
module zap_mem_drain_walker #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_mem_clken,
    output logic [$clog2(DEPTH)-1:0] o_mem_raddr,
    input  logic [WIDTH-1:0]         i_mem_rdata,
    input  logic                     i_mem_rdav,
    output logic                     o_inv,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH)-1:0] o_addr,
    output logic [WIDTH-1:0]         o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);
    localparam logic [CW:0] CRED_LIM  = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW:0]         r_cnt;
    logic [RD_LAT-1:0]   r_tag_vld;
    logic [AW-1:0]       r_tag_addr [RD_LAT];
    logic [AW+WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;

    logic [CW-1:0]       w_inflight;
    logic [CW:0]         w_used;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_drained;

    // Reads still in the RAM pipeline, counted from the tag shift register.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            w_inflight = w_inflight + CW'(r_tag_vld[i]);
    end

    // Credits: every issued read must already own a buffer slot.
    assign w_used  = {1'b0, r_count} + {1'b0, w_inflight};
    assign w_issue = (r_state == S_ISSUE) && (w_used < CRED_LIM);
    assign w_empty = (r_count == '0);
    assign w_push  = r_tag_vld[RD_LAT-1] && i_mem_rdav;
    assign w_pop   = !w_empty && i_ready;
    // Done once nothing is in flight and the last entry leaves this cycle;
    // FLUSH then lands strictly after the final transfer.
    assign w_drained = (r_tag_vld == '0) &&
                       (w_empty || (r_count == CW'(1) && w_pop));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_ISSUE;
            S_ISSUE: if (w_issue && r_cnt == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (w_drained) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Issue counter: one wider than the address so it parks at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_reset)                         r_cnt <= '0;
        else if (r_state == S_IDLE && i_start) r_cnt <= '0;
        else if (w_issue)                    r_cnt <= r_cnt + 1'b1;
    end

    // Tag valid pipe: marks which RAM return cycles belong to real reads.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
        end
    end

    // Tag address pipe, qualified by r_tag_vld so it needs no reset.
    always_ff @(posedge i_clk) begin
        r_tag_addr[0] <= r_cnt[AW-1:0];
        for (int i = 1; i < RD_LAT; i++) r_tag_addr[i] <= r_tag_addr[i-1];
    end

    // Output buffer storage.
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {r_tag_addr[RD_LAT-1], i_mem_rdata};
    end

    // Output buffer pointers and occupancy; push and pop may coincide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // The credit rule makes this unreachable; it guards against regressions.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_push && r_count == FULL_CNT && !w_pop));

    assign o_busy      = (r_state != S_IDLE);
    assign o_mem_clken = o_busy;
    assign o_done      = (r_state == S_DONE);
    assign o_mem_raddr = r_cnt[AW-1:0];
    assign o_valid     = !w_empty;
    assign {o_addr, o_data} = w_empty ? '0 : r_fifo[r_rd_ptr];

`ifdef ZAP_MEM_DRAIN_INV_EN
    assign o_inv = (r_state == S_FLUSH);
`else
    assign o_inv = 1'b0;
`endif

endmodule
